// File: rtl/alu_writeback_stage_pkg.sv
// alu_writeback_stage_pkg: opcodes, FSM states and width defaults shared by the writeback stage
package alu_writeback_stage_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_CNT_W = 16;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_RED = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;
endpackage

// File: rtl/alu_writeback_stage_if.sv
// alu_writeback_stage_if: ALU-result input, register-file write, forwarding and status signals
interface alu_writeback_stage_if #(
  parameter int DATA_W = alu_writeback_stage_pkg::DEF_DATA_W,
  parameter int REG_ADDR_W = alu_writeback_stage_pkg::DEF_REG_ADDR_W,
  parameter int CNT_W = alu_writeback_stage_pkg::DEF_CNT_W
);
  logic in_valid;
  logic in_ready;
  logic [3:0] opcode;
  logic [DATA_W-1:0] alu_result;
  logic alu_ovfl;
  logic [REG_ADDR_W-1:0] rd;
  logic rd_we;
  logic rf_wr_en;
  logic [REG_ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic flag_n;
  logic flag_z;
  logic flag_v;
  logic halted;
  logic [CNT_W-1:0] retired;
  modport master (
    output in_valid, opcode, alu_result, alu_ovfl, rd, rd_we,
    input in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_valid, fwd_addr, fwd_data,
    input flag_n, flag_z, flag_v, halted, retired
  );
  modport slave (
    input in_valid, opcode, alu_result, alu_ovfl, rd, rd_we,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_valid, fwd_addr, fwd_data,
    output flag_n, flag_z, flag_v, halted, retired
  );
endinterface

// File: rtl/alu_writeback_stage_flag_unit.sv
// alu_writeback_stage_flag_unit: N/Z/V flag register with per-opcode update enables
module alu_writeback_stage_flag_unit
  import alu_writeback_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              ovfl_i,
  output logic              n_o,
  output logic              z_o,
  output logic              v_o
);
  logic arith, z_only;
  logic n_q, z_q, v_q, n_d, z_d, v_d;
  always_comb begin
    arith = en_i && (opcode_i == OP_ADD || opcode_i == OP_SUB);
    z_only = en_i && (opcode_i inside {OP_XOR, OP_SLL, OP_SRA, OP_ROR});
    n_d = arith ? result_i[DATA_W-1] : n_q;
    z_d = (arith || z_only) ? (result_i == '0) : z_q;
    v_d = arith ? ovfl_i : v_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      n_q <= n_d;
      z_q <= z_d;
      v_q <= v_d;
    end
  end
  assign n_o = n_q;
  assign z_o = z_q;
  assign v_o = v_q;
endmodule

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: registered ALU writeback with forwarding, flags, halt FSM and retire counter
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  alu_writeback_stage_if.slave bus
);
  state_e state_q, state_d;
  logic acc, flag_en, wr_en_d, wr_en_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0] retired_q, retired_d;
  always_comb begin
    acc = bus.in_valid && state_q == ST_RUN;
    flag_en = acc && bus.opcode != OP_HLT;
    wr_en_d = flag_en && bus.rd_we && bus.rd != '0;
    retired_d = acc ? retired_q + CNT_W'(1) : retired_q;
    state_d = state_q == ST_DRAIN ? ST_HALTED : (acc && bus.opcode == OP_HLT) ? ST_DRAIN : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wr_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      retired_q <= retired_d;
      if (wr_en_d) begin
        addr_q <= bus.rd;
        data_q <= bus.alu_result;
      end
    end
  end
  alu_writeback_stage_flag_unit #(.DATA_W(DATA_W)) u_flags (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(flag_en),
    .opcode_i(bus.opcode),
    .result_i(bus.alu_result),
    .ovfl_i(bus.alu_ovfl),
    .n_o(bus.flag_n),
    .z_o(bus.flag_z),
    .v_o(bus.flag_v)
  );
  assign bus.in_ready = state_q == ST_RUN;
  assign bus.halted = state_q == ST_HALTED;
  assign bus.rf_wr_en = wr_en_q;
  assign bus.rf_wr_addr = addr_q;
  assign bus.rf_wr_data = data_q;
  assign bus.fwd_valid = wr_en_q;
  assign bus.fwd_addr = addr_q;
  assign bus.fwd_data = data_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed and randomized checks against a behavioural writeback model
module tb_alu_writeback_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  alu_writeback_stage_if bus();
  alu_writeback_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int m_phase;
  bit m_we, m_n, m_z, m_v;
  logic [3:0] m_addr;
  logic [15:0] m_data, m_ret;
  task automatic model_reset();
    m_phase = 0;
    m_we = 0;
    m_n = 0;
    m_z = 0;
    m_v = 0;
    m_ret = 0;
  endtask
  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] res, input logic ov, input logic [3:0] r, input logic we);
    bit acc;
    bus.in_valid = v;
    bus.opcode = op;
    bus.alu_result = res;
    bus.alu_ovfl = ov;
    bus.rd = r;
    bus.rd_we = we;
    @(posedge clk);
    acc = v && m_phase == 0;
    m_we = acc && op != 4'hF && we && r != 0;
    if (m_we) begin
      m_addr = r;
      m_data = res;
    end
    if (acc && op <= 1) begin
      m_n = res[15];
      m_z = res == 0;
      m_v = ov;
    end else if (acc && op inside {2, 4, 5, 6}) m_z = res == 0;
    if (acc) m_ret = m_ret + 1;
    m_phase = m_phase == 1 ? 2 : (acc && op == 4'hF) ? 1 : m_phase;
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    bus.in_valid = 1;
    bus.opcode = 4'h0;
    bus.alu_result = 16'h1111;
    bus.alu_ovfl = 1;
    bus.rd = 4'd9;
    bus.rd_we = 1;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1;
    bus.in_valid = 0;
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.rf_wr_en !== 1'b0 || bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b/%b want 0/0", bus.rf_wr_en, bus.fwd_valid); end
    n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.flag_n, bus.flag_z, bus.flag_v}); end
    n_checks++; if (bus.halted !== 1'b0 || bus.retired !== 16'h0) begin n_fail++; $display("FAIL reset_status: halted %b retired %h want 0/0000", bus.halted, bus.retired); end
    n_checks++; if (bus.rf_wr_addr !== 4'h0 || bus.rf_wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_bus: got %h/%h want 0/0000", bus.rf_wr_addr, bus.rf_wr_data); end
  endtask
  task automatic test_add_flags();
    step(1, 4'h0, 16'h8000, 1, 4'd3, 1);
    n_checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== 4'd3 || bus.rf_wr_data !== 16'h8000) begin n_fail++; $display("FAIL add_write: got %b/%h/%h want 1/3/8000", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data); end
    n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b101) begin n_fail++; $display("FAIL add_flags: got %b want 101", {bus.flag_n, bus.flag_z, bus.flag_v}); end
    n_checks++; if (bus.retired !== 16'd1) begin n_fail++; $display("FAIL add_retired: got %0d want 1", bus.retired); end
    idle();
    n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL add_one_shot: got %b want 0", bus.rf_wr_en); end
  endtask
  task automatic test_z_only();
    step(1, 4'h2, 16'h0000, 0, 4'd4, 1);
    n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b111) begin n_fail++; $display("FAIL xor_flags: got %b want 111", {bus.flag_n, bus.flag_z, bus.flag_v}); end
    step(1, 4'h3, 16'h0000, 0, 4'd4, 1);
    n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b111) begin n_fail++; $display("FAIL red_hold0: got %b want 111", {bus.flag_n, bus.flag_z, bus.flag_v}); end
    step(1, 4'h3, 16'h1234, 1, 4'd4, 1);
    n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b111) begin n_fail++; $display("FAIL red_hold1: got %b want 111", {bus.flag_n, bus.flag_z, bus.flag_v}); end
    step(1, 4'hA, 16'h0042, 0, 4'd6, 1);
    n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b111 || bus.rf_wr_en !== 1'b1 || bus.rf_wr_data !== 16'h0042) begin n_fail++; $display("FAIL llb_plain: flags %b we %b data %h want 111/1/0042", {bus.flag_n, bus.flag_z, bus.flag_v}, bus.rf_wr_en, bus.rf_wr_data); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] r0;
    r0 = bus.retired;
    step(1, 4'h1, 16'h00AA, 0, 4'd5, 1);
    n_checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== 4'd5 || bus.rf_wr_data !== 16'h00AA) begin n_fail++; $display("FAIL b2b_sub: got %b/%h/%h want 1/5/00aa", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data); end
    n_checks++; if (bus.fwd_valid !== 1'b1 || bus.fwd_addr !== 4'd5 || bus.fwd_data !== 16'h00AA) begin n_fail++; $display("FAIL b2b_fwd: got %b/%h/%h want 1/5/00aa", bus.fwd_valid, bus.fwd_addr, bus.fwd_data); end
    step(1, 4'h4, 16'h5555, 0, 4'd0, 1);
    n_checks++; if (bus.rf_wr_en !== 1'b0 || bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_r0: got %b/%b want 0/0", bus.rf_wr_en, bus.fwd_valid); end
    n_checks++; if (bus.retired !== r0 + 16'd2) begin n_fail++; $display("FAIL b2b_retired: got %0d want %0d", bus.retired, r0 + 16'd2); end
  endtask
  task automatic test_random();
    logic [3:0] ops[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB};
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 9)], 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), 4'($urandom), 1'($urandom));
      n_checks++; if (bus.rf_wr_en !== m_we || bus.fwd_valid !== m_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b/%b want %b", i, bus.rf_wr_en, bus.fwd_valid, m_we); end
      if (m_we) begin
        n_checks++; if (bus.rf_wr_addr !== m_addr || bus.rf_wr_data !== m_data || bus.fwd_addr !== m_addr || bus.fwd_data !== m_data) begin n_fail++; $display("FAIL rnd_wr[%0d]: got %h/%h fwd %h/%h want %h/%h", i, bus.rf_wr_addr, bus.rf_wr_data, bus.fwd_addr, bus.fwd_data, m_addr, m_data); end
      end
      n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== {m_n, m_z, m_v}) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, {bus.flag_n, bus.flag_z, bus.flag_v}, {m_n, m_z, m_v}); end
      n_checks++; if (bus.retired !== m_ret || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_status[%0d]: retired %0d ready %b want %0d/1", i, bus.retired, bus.in_ready, m_ret); end
    end
  endtask
  task automatic test_halt();
    logic [2:0] fl;
    logic [15:0] r0;
    do_reset();
    step(1, 4'h0, 16'h0123, 0, 4'd2, 1);
    n_checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== 4'd2 || bus.rf_wr_data !== 16'h0123) begin n_fail++; $display("FAIL halt_add: got %b/%h/%h want 1/2/0123", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data); end
    step(1, 4'hF, 16'h0000, 1, 4'd8, 1);
    n_checks++; if (bus.in_ready !== 1'b0 || bus.halted !== 1'b0 || bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL halt_drain: ready %b halted %b we %b want 0/0/0", bus.in_ready, bus.halted, bus.rf_wr_en); end
    n_checks++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000 || bus.retired !== 16'd2) begin n_fail++; $display("FAIL halt_hlt: flags %b retired %0d want 000/2", {bus.flag_n, bus.flag_z, bus.flag_v}, bus.retired); end
    step(1, 4'h0, 16'h0000, 1, 4'd9, 1);
    n_checks++; if (bus.halted !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_halted: halted %b ready %b want 1/0", bus.halted, bus.in_ready); end
    fl = {bus.flag_n, bus.flag_z, bus.flag_v};
    r0 = bus.retired;
    for (int i = 0; i < 8; i++) begin
      step(1, 4'($urandom_range(0, 2)), 16'($urandom), 1, 4'd7, 1);
      n_checks++; if (bus.rf_wr_en !== 1'b0 || bus.retired !== r0 || {bus.flag_n, bus.flag_z, bus.flag_v} !== fl || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_frozen[%0d]: we %b retired %0d flags %b halted %b", i, bus.rf_wr_en, bus.retired, {bus.flag_n, bus.flag_z, bus.flag_v}, bus.halted); end
    end
    do_reset();
    n_checks++; if (bus.halted !== 1'b0 || bus.in_ready !== 1'b1 || bus.retired !== 16'd0) begin n_fail++; $display("FAIL halt_reset: halted %b ready %b retired %0d want 0/1/0", bus.halted, bus.in_ready, bus.retired); end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++) step(1, 4'h3, 16'h0001, 0, 4'd0, 0);
    n_checks++; if (bus.retired !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h want ffff", bus.retired); end
    step(1, 4'h3, 16'h0001, 0, 4'd0, 0);
    n_checks++; if (bus.retired !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", bus.retired); end
  endtask
  task automatic test_reset_mid();
    step(1, 4'h1, 16'hF000, 1, 4'd7, 1);
    n_checks++; if (bus.rf_wr_en !== 1'b1 || {bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b101) begin n_fail++; $display("FAIL mid_pre: we %b flags %b want 1/101", bus.rf_wr_en, {bus.flag_n, bus.flag_z, bus.flag_v}); end
    do_reset();
    n_checks++; if (bus.rf_wr_en !== 1'b0 || {bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000) begin n_fail++; $display("FAIL mid_reset: we %b flags %b want 0/000", bus.rf_wr_en, {bus.flag_n, bus.flag_z, bus.flag_v}); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.retired !== 16'd0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL mid_state: ready %b retired %0d halted %b want 1/0/0", bus.in_ready, bus.retired, bus.halted); end
    step(1, 4'h1, 16'h0000, 0, 4'd7, 1);
    do_reset();
    step(1, 4'hF, 16'h0, 0, 4'd0, 0);
    do_reset();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.rf_wr_en !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL drain_reset: ready %b we %b halted %b want 1/0/0", bus.in_ready, bus.rf_wr_en, bus.halted); end
  endtask
  initial begin
    bus.in_valid = 0;
    bus.opcode = 0;
    bus.alu_result = 0;
    bus.alu_ovfl = 0;
    bus.rd = 0;
    bus.rd_we = 0;
    model_reset();
    #1;
    test_reset();
    test_add_flags();
    test_z_only();
    test_back_to_back();
    test_random();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
